fetch_stage: RTL

Instruction-fetch stage of the RV32I pipelined core. It owns the program counter, issues word fetches to instruction memory over a valid/ready request channel, and pairs each in-order response with its PC. The resulting {pc, instr} stream goes out over a valid/ready handshake that feeds the IF/ID pipeline register directly. Redirects from the execute stage restart fetch at a new PC and discard every stale instruction.

---
 rtl/fetch_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage.
// Owns the PC, issues word fetches over a valid/ready request channel, pairs
// in-order responses with their PCs in a small circular buffer and presents
// {pc, instr} downstream over valid/ready. Redirects restart fetch and discard
// stale responses through a kill counter.
// Optional feature macro: FETCH_STALL_CNT_EN (adds the stall_cycles counter port).
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk,
   input  logic        async_rst_n,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef logic [AW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   logic [31:0] pc_q;

   // output buffer of {pc, instr}
   logic [31:0] fb_pc    [DEPTH];
   logic [31:0] fb_instr [DEPTH];
   ptr_t        fb_head;
   ptr_t        fb_tail;
   cnt_t        occ;

   // PCs of accepted requests whose responses are still live
   logic [31:0] pend_pc [DEPTH];
   ptr_t        pend_head;
   ptr_t        pend_tail;
   cnt_t        pend_cnt;

   // responses still owed by memory for requests made before a redirect
   cnt_t        kill;

   logic [CW+1:0] credit_used;
   logic          req_fire;
   logic          rsp_live;
   logic          pop;
   logic [1:0]    unused_rpc_lo;

   assign unused_rpc_lo = redirect_pc[1:0];

   // inflight counts both live pending requests and responses still to be killed
   assign credit_used    = (CW+2)'(pend_cnt) + (CW+2)'(kill) + (CW+2)'(occ);
   assign imem_req_valid = async_rst_n && !redirect && (credit_used < (CW+2)'(DEPTH));
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign rsp_live       = imem_rsp_valid && (kill == '0) && !redirect;

   assign out_valid = (occ != '0);
   assign pop       = out_valid && out_ready;
   assign out_pc    = fb_pc[fb_head];
   assign out_instr = fb_instr[fb_head];

   // PC, pending queue, kill counter and output buffer update
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         pc_q      <= RESET_PC;
         fb_head   <= '0;
         fb_tail   <= '0;
         occ       <= '0;
         pend_head <= '0;
         pend_tail <= '0;
         pend_cnt  <= '0;
         kill      <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fb_pc[i]    <= '0;
            fb_instr[i] <= '0;
            pend_pc[i]  <= '0;
         end
      end else if (redirect) begin
         pc_q              <= {redirect_pc[31:2], 2'b00};
         occ               <= '0;
         fb_tail           <= fb_head;
         fb_pc[fb_head]    <= '0;
         fb_instr[fb_head] <= '0;
         pend_cnt          <= '0;
         pend_tail         <= pend_head;
         // a response landing this cycle is dropped here, so it leaves the owed count
         kill              <= kill + pend_cnt - cnt_t'(imem_rsp_valid);
      end else begin
         if (req_fire) begin
            pend_pc[pend_tail] <= pc_q;
            pend_tail          <= pend_tail + ptr_t'(1);
            pc_q               <= pc_q + 32'd4;
         end
         if (imem_rsp_valid && (kill != '0)) begin
            kill <= kill - cnt_t'(1);
         end
         if (rsp_live) begin
            fb_pc[fb_tail]    <= pend_pc[pend_head];
            fb_instr[fb_tail] <= imem_rsp_data;
            fb_tail           <= fb_tail + ptr_t'(1);
            pend_head         <= pend_head + ptr_t'(1);
         end
         if (pop) begin
            fb_head <= fb_head + ptr_t'(1);
         end
         pend_cnt <= pend_cnt + cnt_t'(req_fire) - cnt_t'(rsp_live);
         occ      <= occ + cnt_t'(rsp_live) - cnt_t'(pop);
      end
   end

`ifdef FETCH_STALL_CNT_EN
   // saturating count of cycles where downstream holds off a valid instruction
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         stall_cycles <= '0;
      end else if (out_valid && !out_ready && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule
